// File: rtl/fetch_pkg.sv
// Shared fetch-side types and defaults.
// Holds XLEN/ILEN, default reset PC, buffer depth and the PC step helper.
package fetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 64'h0;
  localparam int FETCH_DEPTH = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_inc(
    input logic [XLEN-1:0] pc
  );
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small registered FIFO with synchronous clear and occupancy count.
// Ports: clk, rst_n, i_clr, i_push/i_din, i_pop, o_dout (head, 0 when empty), o_count.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic [CW-1:0]    o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Clear dominates; a pop on empty is ignored.
  assign w_push = i_push && !i_clr;
  assign w_pop  = i_pop && !i_clr && (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr <= ptr_inc(r_wr);
      end
      if (w_pop) begin
        r_rd <= ptr_inc(r_rd);
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Head reads as zero when empty so the decode side sees clean data.
  assign o_dout  = (r_cnt != '0) ? r_mem[r_rd] : '0;
  assign o_count = r_cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited requests, in-order responses, redirect flush.
// Ports: imem req/rsp channel, redirect from execute, if_* valid/ready to decode.
import fetch_pkg::*;

module fetch_unit #(
  parameter logic [63:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = FETCH_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIM = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_out;
  logic [CW-1:0]   r_drop;

  logic [CW-1:0]   w_cnt;
  logic [CW:0]     w_used;
  logic            w_req_valid;
  logic            w_fire;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_out_left;
  logic [XLEN-1:0] w_tgt;
  fetch_entry_t    w_din;
  fetch_entry_t    w_head;

  // Credits cover both in-flight requests and buffered words.
  assign w_used      = {1'b0, r_out} + {1'b0, w_cnt};
  assign w_req_valid = rst_n && !redirect_valid && (w_used < LIM);
  assign w_fire      = w_req_valid && imem_req_ready;

  // Outstanding count once this cycle's response is retired.
  assign w_out_left = r_out - CW'(imem_rsp_valid);

  assign w_push = imem_rsp_valid && !redirect_valid
               && (r_drop == '0);
  assign w_pop  = if_valid && if_ready && !redirect_valid;
  assign w_tgt  = {redirect_pc[63:2], 2'b00};

  assign w_din.pc    = r_rsp_pc;
  assign w_din.instr = imem_rsp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_out    <= '0;
      r_drop   <= '0;
    end else begin
      r_out <= w_out_left + CW'(w_fire);
      if (redirect_valid) begin
        r_pc     <= w_tgt;
        r_rsp_pc <= w_tgt;
        r_drop   <= w_out_left;
      end else begin
        if (w_fire) begin
          r_pc <= pc_inc(r_pc);
        end
        if (imem_rsp_valid && (r_drop != '0)) begin
          r_drop <= r_drop - CW'(1);
        end
        if (w_push) begin
          r_rsp_pc <= pc_inc(r_rsp_pc);
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t)),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (redirect_valid),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (w_cnt)
  );

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign if_valid       = (w_cnt != '0);
  assign if_instr       = w_head.instr;
  assign if_pc          = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a queue-based memory/decode model.
// Second instance covers a reset PC near the top of the address space.
module tb_fetch_unit;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;

  logic        w_rst_n;
  logic        w_req_valid;
  logic [63:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_if_valid;
  logic [31:0] w_if_instr;
  logic [63:0] w_if_pc;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  fetch_unit #(
    .RESET_PC (64'hFFFF_FFFF_FFFF_FFF8)
  ) u_dut_w (
    .clk            (clk),
    .rst_n          (w_rst_n),
    .imem_req_valid (w_req_valid),
    .imem_req_ready (1'b1),
    .imem_req_addr  (w_req_addr),
    .imem_rsp_valid (w_rsp_valid),
    .imem_rsp_data  (w_rsp_data),
    .redirect_valid (1'b0),
    .redirect_pc    (64'h0),
    .if_valid       (w_if_valid),
    .if_ready       (1'b1),
    .if_instr       (w_if_instr),
    .if_pc          (w_if_pc)
  );

  typedef struct {
    logic [63:0] addr;
    int          ep;
    int          due;
  } req_t;

  req_t        oq[$];
  logic [63:0] mf[$];
  logic [63:0] exp_pc;
  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;
  int ep = 0;
  int lat = 0;
  int obs_fire = 0;
  int first_v = -1;
  int base = 0;
  logic [63:0] first_pc;
  logic [63:0] obs_pc;

  function automatic logic [31:0] word(input logic [63:0] a);
    return (a[33:2] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h13;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic redir,
                      input logic [63:0] rpc, input logic mrdy);
    logic rsp;
    logic erv;
    logic fire;
    logic pop;
    req_t it;
    @(negedge clk);
    if_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = mrdy;
    rsp = (oq.size() != 0) && (oq[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? word(oq[0].addr) : 32'($urandom);
    #1;
    erv = !redir && ((oq.size() + mf.size()) < D);
    chk("req_valid", 64'(imem_req_valid), 64'(erv));
    if (erv) chk("req_addr", imem_req_addr, exp_pc);
    chk("if_valid", 64'(if_valid), 64'(mf.size() != 0));
    if (mf.size() != 0) begin
      chk("if_pc", if_pc, mf[0]);
      chk("if_instr", 64'(if_instr), 64'(word(mf[0])));
    end
    if (imem_req_valid && mrdy) obs_fire++;
    if (if_valid) obs_pc = if_pc;
    if (if_valid && first_v < 0) begin
      first_v  = cyc - base;
      first_pc = if_pc;
    end
    fire = erv && mrdy;
    pop  = (mf.size() != 0) && rdy;
    @(posedge clk);
    cyc++;
    if (rsp) begin
      it = oq.pop_front();
      if (!redir && it.ep == ep) mf.push_back(it.addr);
    end
    if (pop && !redir) void'(mf.pop_front());
    if (fire) begin
      oq.push_back('{exp_pc, ep, cyc + lat});
      exp_pc = exp_pc + 64'd4;
    end
    if (redir) begin
      mf.delete();
      ep++;
      exp_pc = {rpc[63:2], 2'b00};
    end
  endtask

  task automatic reset_pulse(input bit at_start);
    if (!at_start) begin
      @(negedge clk);
      #2;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_if_instr", 64'(if_instr), 64'd0);
    chk("rst_if_pc", if_pc, 64'd0);
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    if_ready       = 1'b0;
    oq.delete();
    mf.delete();
    ep++;
    exp_pc = 64'h0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    base    = cyc;
    first_v = -1;
  endtask

  initial begin
    logic [63:0] raddr[$];
    logic [63:0] ipc[$];
    logic [63:0] wexp[3];
    logic        pend;
    logic [63:0] pend_a;
    logic        wfire;
    logic [63:0] wa;
    int          k;

    w_rst_n        = 1'b0;
    w_rsp_valid    = 1'b0;
    w_rsp_data     = '0;
    redirect_pc    = '0;
    imem_rsp_data  = '0;

    // Reset release, 1-cycle memory, decode always ready.
    reset_pulse(1'b1);
    lat = 0;
    repeat (12) step(1'b1, 1'b0, 64'h0, 1'b1);
    chk("first_if_latency", 64'(first_v), 64'd2);
    chk("first_if_pc", first_pc, 64'h0);

    // Decode stall: credits cap requests, head held.
    reset_pulse(1'b0);
    obs_fire = 0;
    repeat (10) step(1'b0, 1'b0, 64'h0, 1'b1);
    chk("stall_reqs_le2", 64'(obs_fire <= 2), 64'd1);
    chk("stall_head_pc", obs_pc, 64'h0);
    repeat (10) step(1'b1, 1'b0, 64'h0, 1'b1);

    // Redirect with two requests in flight.
    lat = 3;
    k = 0;
    while (oq.size() < 2 && k < 10) begin
      step(1'b1, 1'b0, 64'h0, 1'b1);
      k++;
    end
    chk("two_in_flight", 64'(oq.size()), 64'd2);
    step(1'b1, 1'b1, 64'h1002, 1'b1);
    first_v = -1;
    base    = cyc;
    lat     = 0;
    repeat (12) step(1'b1, 1'b0, 64'h0, 1'b1);
    chk("redir_first_pc", first_pc, 64'h1000);

    // Redirect coincident with response and pop.
    k = 0;
    while (!(oq.size() != 0 && oq[0].due <= cyc && mf.size() != 0)
           && k < 10) begin
      step(1'b1, 1'b0, 64'h0, 1'b1);
      k++;
    end
    chk("coincide_reached", 64'(k < 10), 64'd1);
    step(1'b1, 1'b1, 64'h2000, 1'b1);
    step(1'b1, 1'b0, 64'h0, 1'b1);
    chk("coincide_empty", 64'(if_valid), 64'd0);
    repeat (8) step(1'b1, 1'b0, 64'h0, 1'b1);

    // Back-to-back redirects, last wins.
    lat = 2;
    repeat (3) step(1'b1, 1'b0, 64'h0, 1'b1);
    step(1'b1, 1'b1, 64'h3000, 1'b1);
    step(1'b1, 1'b1, 64'h4000, 1'b1);
    step(1'b1, 1'b1, 64'h5007, 1'b1);
    repeat (12) step(1'b1, 1'b0, 64'h0, 1'b1);

    // Wrap through the top of the address space.
    lat = 0;
    step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
    repeat (10) step(1'b1, 1'b0, 64'h0, 1'b1);

    // Randomised traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      logic [63:0] rpc;
      if (i % 37 == 0) lat = $urandom_range(0, 3);
      rpc = ($urandom_range(0, 3) == 0)
          ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
          : {32'($urandom), 32'($urandom)};
      if (i == 200) reset_pulse(1'b0);
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
           rpc, $urandom_range(0, 3) != 0);
    end

    // Reset PC near the top: FFF8, FFFC, then 0.
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    wexp[0] = 64'hFFFF_FFFF_FFFF_FFF8;
    wexp[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    wexp[2] = 64'h0;
    pend   = 1'b0;
    pend_a = '0;
    @(posedge clk);
    #2 w_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      w_rsp_valid = pend;
      w_rsp_data  = word(pend_a);
      #1;
      wfire = w_req_valid;
      wa    = w_req_addr;
      if (w_req_valid) raddr.push_back(w_req_addr);
      if (w_if_valid) begin
        ipc.push_back(w_if_pc);
        chk("wrap_instr", 64'(w_if_instr), 64'(word(w_if_pc)));
      end
      @(posedge clk);
      pend   = wfire;
      pend_a = wa;
    end
    chk("wrap_nreq", 64'(raddr.size() >= 3), 64'd1);
    chk("wrap_nif", 64'(ipc.size() >= 3), 64'd1);
    for (int i = 0; i < 3; i++) begin
      if (i < raddr.size()) chk("wrap_req_addr", raddr[i], wexp[i]);
      if (i < ipc.size()) chk("wrap_if_pc", ipc[i], wexp[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
